// File: rtl/clk_div_mon.sv
// rtl/clk_div_mon.sv - phase-length lock monitor for a programmable divided clock
// Measures each high/low phase of mon_clk_i in clk_i cycles, compares it with
// half_period_i, and reports per-phase lengths, lock and a sticky error.
module clk_div_mon #(
  parameter int DLY      = 1,
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] half_period_i,
  input  logic             mon_clk_i,
  input  logic             err_clr_i,
  output logic             meas_vld_o,
  output logic [WIDTH:0]   meas_len_o,
  output logic             meas_lvl_o,
  output logic             lock_o,
  output logic             err_o
);

  localparam logic [3:0]   LOCK_MAX = 4'(LOCK_CNT);
  localparam logic [WIDTH:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

  state_e           state_q;
  logic             mon_q;
  logic [WIDTH-1:0] hp_q;
  logic [WIDTH:0]   cnt_q;
  logic [3:0]       match_q;
  logic             ovr_q;
  logic             lock_q;
  logic             err_q;
  logic             meas_vld_q;
  logic [WIDTH:0]   meas_len_q;
  logic             meas_lvl_q;

  logic             edge_det;
  logic             at_hp;
  logic             cfg_chg;
  logic             go_idle;
  logic [WIDTH:0]   cnt_d;
  logic [3:0]       match_d;
  // Register updates carry no modelled delay; DLY is kept only so existing
  // instantiations that pass it still elaborate.
  logic             unused_dly;

  // Edge detect, match/overrun compare and saturating increments.
  always_comb begin
    edge_det   = (mon_clk_i != mon_q);
    at_hp      = (cnt_q == {1'b0, half_period_i});
    cfg_chg    = (half_period_i != hp_q);
    go_idle    = !en_i || (half_period_i == '0);
    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    match_d    = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 4'd1;
    unused_dly = (DLY != 0);
  end

  // Monitor FSM: front end, phase counter, lock tracking and sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      mon_q      <= 1'b0;
      hp_q       <= '0;
      cnt_q      <= '0;
      match_q    <= '0;
      ovr_q      <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      meas_vld_q <= 1'b0;
      meas_len_q <= '0;
      meas_lvl_q <= 1'b0;
    end else begin
      mon_q      <= mon_clk_i;
      hp_q       <= half_period_i;
      meas_vld_q <= 1'b0;
      // A clear is overridden below if an error event lands in the same cycle.
      if (err_clr_i) err_q <= 1'b0;

      if (go_idle) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        match_q <= '0;
        ovr_q   <= 1'b0;
        lock_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SYNC;
          end
          ST_SYNC: begin
            // The partial phase before the first edge is never measured.
            if (!cfg_chg && edge_det) begin
              cnt_q   <= CNT_ONE;
              ovr_q   <= 1'b0;
              state_q <= ST_MEAS;
            end
          end
          ST_MEAS: begin
            if (cfg_chg) begin
              state_q <= ST_SYNC;
              cnt_q   <= '0;
              match_q <= '0;
              ovr_q   <= 1'b0;
              lock_q  <= 1'b0;
            end else if (edge_det) begin
              cnt_q      <= CNT_ONE;
              ovr_q      <= 1'b0;
              meas_vld_q <= 1'b1;
              meas_len_q <= cnt_q;
              meas_lvl_q <= mon_q;
              // A phase already flagged as overrun was counted as its mismatch.
              if (!ovr_q) begin
                if (at_hp) begin
                  match_q <= match_d;
                  if (match_d == LOCK_MAX) lock_q <= 1'b1;
                end else begin
                  match_q <= '0;
                  lock_q  <= 1'b0;
                  if (lock_q) err_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_d;
              if (at_hp && !ovr_q) begin
                ovr_q   <= 1'b1;
                match_q <= '0;
                lock_q  <= 1'b0;
                if (lock_q) err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign meas_vld_o = meas_vld_q;
  assign meas_len_o = meas_len_q;
  assign meas_lvl_o = meas_lvl_q;
  assign lock_o     = lock_q;
  assign err_o      = err_q;

endmodule
